// File: rtl/fetch_buffer.sv
// Instruction realignment buffer. Returned 32-bit fetch words are split into 16-bit
// parcels, each tagged with its own PC, and the head of the queue is presented as one
// whole RV32IC instruction (compressed or 32-bit, possibly straddling two words).
module fetch_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rdata,
  input  logic        in_ready,
  input  logic        in_align,
  input  logic        in_clear,
  input  logic        in_stall,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_done,
  output logic        out_stall
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  // Parcel storage and the PC of each parcel
  logic [15:0]   parcel_q [DEPTH];
  logic [15:0]   parcel_d [DEPTH];
  logic [31:0]   ppc_q    [DEPTH];
  logic [31:0]   ppc_d    [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic          align_q, align_d;

  logic [PW-1:0] count;
  logic [PW-1:0] free;
  logic [IW-1:0] rd_idx, rd1_idx;
  logic [IW-1:0] wr_idx, wr1_idx;
  logic [15:0]   p0, p1;
  logic          head_is_32;
  logic [PW-1:0] head_need;
  logic [PW-1:0] push_need;
  logic          push_req, push_fits, push_en, pop_en;

  // Only the word-aligned part of in_pc is meaningful
  logic          unused_pc_lsb;
  assign unused_pc_lsb = ^in_pc[1:0];

  // Occupancy, head decode and outputs, all from registered state
  always_comb begin
    count      = wr_q - rd_q;
    free       = PW'(DEPTH) - count;
    rd_idx     = rd_q[IW-1:0];
    rd1_idx    = rd_idx + IW'(1);
    wr_idx     = wr_q[IW-1:0];
    wr1_idx    = wr_idx + IW'(1);
    p0         = parcel_q[rd_idx];
    p1         = parcel_q[rd1_idx];
    head_is_32 = (p0[1:0] == 2'b11);
    head_need  = head_is_32 ? PW'(2) : PW'(1);
    out_done   = (count >= head_need);
    out_pc     = 32'h0;
    out_instr  = 32'h0;
    if (out_done) begin
      out_pc    = ppc_q[rd_idx];
      out_instr = head_is_32 ? {p1, p0} : {16'h0, p0};
    end
    // Leaves room for two words already requested by fetch
    out_stall  = (count > PW'(DEPTH - 4));
  end

  // Push/pop qualification
  always_comb begin
    push_need = align_q ? PW'(1) : PW'(2);
    push_req  = in_ready && !in_clear;
    push_fits = (free >= push_need);
    push_en   = push_req && push_fits;
    pop_en    = out_done && !in_stall && !in_clear;
  end

  // Pointer and align-pending next state; a clear overrides push and pop
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    align_d = align_q;
    if (in_clear) begin
      rd_d    = '0;
      wr_d    = '0;
      align_d = in_align;
    end else begin
      if (pop_en) begin
        rd_d = rd_q + head_need;
      end
      if (push_en) begin
        wr_d    = wr_q + push_need;
        align_d = 1'b0;
      end
    end
  end

  // Parcel write: after a halfword-aligned redirect only the upper parcel is kept
  always_comb begin
    parcel_d = parcel_q;
    ppc_d    = ppc_q;
    if (push_en) begin
      if (align_q) begin
        parcel_d[wr_idx] = in_rdata[31:16];
        ppc_d[wr_idx]    = {in_pc[31:2], 2'b10};
      end else begin
        parcel_d[wr_idx]  = in_rdata[15:0];
        ppc_d[wr_idx]     = {in_pc[31:2], 2'b00};
        parcel_d[wr1_idx] = in_rdata[31:16];
        ppc_d[wr1_idx]    = {in_pc[31:2], 2'b10};
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      align_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      align_q <= align_d;
    end
  end

  // Storage register; contents are don't-care outside the rd..wr window
  always_ff @(posedge clock) begin
    parcel_q <= parcel_d;
    ppc_q    <= ppc_d;
  end

`ifndef SYNTHESIS
  // Flag a push that arrives with no room; it is dropped and state is unchanged
  always_ff @(posedge clock) begin
    if (reset && push_req) begin
      assert (push_fits) else $error("fetch_buffer: push dropped, queue full");
    end
  end
`endif

endmodule
